// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the control decoder and the fetch stage.
//   - PCSrc encodings driven by the decoder (3 bits)
//   - fetch FSM states
//   - sign-extended, word-scaled branch offset helper
package mips_pkg;

  typedef enum logic [2:0] {
    PC_SEQ = 3'b000,
    PC_JR  = 3'b001,
    PC_BEQ = 3'b010,
    PC_BNE = 3'b011,
    PC_J   = 3'b100
  } pcsrc_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_e;

  // 16-bit branch immediate -> byte offset (sign-extended, shifted by 2)
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// npc_calc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc         in   32  address of the held instruction
//   inst_idx   in   26  low 26 bits of the held instruction (branch imm / jump index)
//   rs_data    in   32  jr target
//   pc_src     in   3   decoder PCSrc
//   next_pc    out  32  selected next PC (wraps modulo 2^32, not yet aligned)
//   misaligned out  1   next_pc[1:0] != 0
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst_idx,
  input  logic [31:0] rs_data,
  input  logic [2:0]  pc_src,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc4;
  assign pc4 = pc + 32'd4;

  always_comb begin
    next_pc = pc4;
    case (pc_src)
      PC_JR:          next_pc = rs_data;
      PC_BEQ, PC_BNE: next_pc = pc4 + branch_offset(inst_idx[15:0]);
      PC_J:           next_pc = {pc4[31:28], inst_idx, 2'b00};
      default:        next_pc = pc4;  // seq and unused encodings
    endcase
  end

  // Only the jr path can produce a non-word target.
  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage. Holds the PC, fetches one word at a
// time over a req/ready + rvalid handshake, presents the held instruction to
// the decoder and advances the PC on commit using the decoder's PCSrc.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : misaligned target on commit -> PC kept, sticky fetch_err, S_ERR
//   undefined : target forced to word alignment, fetch_err tied 0
// Ports:
//   clk, rst_n (async active-low)
//   pc_src[2:0], rs_data[31:0], commit      from decoder / register file
//   imem_req, imem_addr[31:0]               fetch request
//   imem_ready, imem_rvalid, imem_rdata     memory handshake
//   inst[31:0], inst_valid, pc, pc_plus4    to decoder
//   fetch_err                               sticky misalignment flag
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_src,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  inst_reg, inst_next;
  logic [31:0]  npc;
  logic         misaligned;

  npc_calc u_npc_calc (
    .pc         (pc_reg),
    .inst_idx   (inst_reg[25:0]),
    .rs_data    (rs_data),
    .pc_src     (pc_src),
    .next_pc    (npc),
    .misaligned (misaligned)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic err_reg, err_next;
`else
  logic unused_npc;
  assign unused_npc = ^{misaligned, npc[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= INST_NOP;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_reg   <= err_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
`ifdef IFETCH_ALIGN_CHECK_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      S_FETCH: begin
        if (imem_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        // rvalid is only meaningful here; stale beats elsewhere are dropped.
        if (imem_rvalid) begin
          inst_next  = imem_rdata;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (commit) begin
          inst_next  = INST_NOP;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misaligned) begin
            err_next   = 1'b1;
            state_next = S_ERR;
          end else begin
            pc_next    = npc;
            state_next = S_FETCH;
          end
`else
          pc_next    = {npc[31:2], 2'b00};
          state_next = S_FETCH;
`endif
        end
      end
      S_ERR: begin
        state_next = S_ERR;  // left only through reset
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Request is suppressed combinationally while reset is asserted.
  assign imem_req   = rst_n && (state_reg == S_FETCH);
  assign imem_addr  = pc_reg;
  assign inst       = inst_reg;
  assign inst_valid = (state_reg == S_HOLD);
  assign pc         = pc_reg;
  assign pc_plus4   = pc_reg + 32'd4;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_err  = err_reg;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_src;
  logic [31:0] rs_data;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .rs_data     (rs_data),
    .commit      (commit),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  src;
    logic [31:0] rs;
    logic [31:0] addr;  // expected fetch address
    logic [31:0] nxt;   // expected next fetch address after commit
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for a request, check its address, then return the word so the DUT
  // ends up holding it.
  task automatic fetch_to_hold(input logic [31:0] exp_addr, input logic [31:0] rdata);
    int n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("req_drop_wait", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("inst_valid_hold", {31'd0, inst_valid}, 32'd1);
    chk("inst_hold", inst, rdata);
    chk("pc_hold", pc, exp_addr);
  endtask

  task automatic commit_and_check(input logic [2:0] src, input logic [31:0] rs,
                                  input logic [31:0] exp_next);
    commit  = 1'b1;
    pc_src  = src;
    rs_data = rs;
    @(negedge clk);
    commit  = 1'b0;
    chk("inst_valid_after", {31'd0, inst_valid}, 32'd0);
    chk("inst_nop_after", inst, 32'd0);
    chk("req_after", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, exp_next);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0020, 3'b000, 32'h0,         32'h0000_3000, 32'h0000_3004};
    vecs[1]  = '{32'h1000_FFFE, 3'b010, 32'h0,         32'h0000_3004, 32'h0000_3000};
    vecs[2]  = '{32'h1000_FFFF, 3'b010, 32'h0,         32'h0000_3000, 32'h0000_3000};
    vecs[3]  = '{32'h0000_0000, 3'b000, 32'h0,         32'h0000_3000, 32'h0000_3004};
    vecs[4]  = '{32'h0000_0000, 3'b000, 32'h0,         32'h0000_3004, 32'h0000_3008};
    vecs[5]  = '{32'h0800_0C10, 3'b100, 32'h0,         32'h0000_3008, 32'h0000_3040};
    vecs[6]  = '{32'h1400_0010, 3'b011, 32'h0,         32'h0000_3040, 32'h0000_3084};
    vecs[7]  = '{32'h0000_0008, 3'b001, 32'h0001_0000, 32'h0000_3084, 32'h0001_0000};
    vecs[8]  = '{32'h1234_5678, 3'b101, 32'hAAAA_0000, 32'h0001_0000, 32'h0001_0004};
    vecs[9]  = '{32'h1000_0100, 3'b111, 32'h0,         32'h0001_0004, 32'h0001_0008};
    vecs[10] = '{32'h0000_0008, 3'b001, 32'hFFFF_FFFC, 32'h0001_0008, 32'hFFFF_FFFC};
    vecs[11] = '{32'h0000_0000, 3'b000, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
    vecs[12] = '{32'h1000_0003, 3'b010, 32'h0,         32'h0000_0000, 32'h0000_0010};
    vecs[13] = '{32'h0BFF_FFFF, 3'b100, 32'h0,         32'h0000_0010, 32'h0FFF_FFFC};
    vecs[14] = '{32'h0000_0008, 3'b001, 32'h0000_3000, 32'h0FFF_FFFC, 32'h0000_3000};

    rst_n = 1'b0; pc_src = 3'b000; rs_data = '0; commit = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    $display("txn reset: addr=%h req=%0d", imem_addr, imem_req);

    // Table-driven fetch/commit transactions
    for (int i = 0; i < 15; i++) begin
      fetch_to_hold(vecs[i].addr, vecs[i].rdata);
      commit_and_check(vecs[i].src, vecs[i].rs, vecs[i].nxt);
      $display("txn %0d: addr=%h inst=%h src=%0d next=%h", i, vecs[i].addr,
               vecs[i].rdata, vecs[i].src, imem_addr);
    end

    // Memory stall: ready low, commit and stray rvalid must be ignored
    for (int i = 0; i < 5; i++) begin
      commit = 1'b1; pc_src = 3'b100; imem_rvalid = i[0]; imem_rdata = 32'h0BAD_0000;
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0000_3000);
      chk("stall_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    commit = 1'b0; imem_rvalid = 1'b0;
    // Slow rvalid: commit during S_WAIT is ignored too
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      commit = 1'b1;
      @(negedge clk);
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    commit = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_1111;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("slow_inst", inst, 32'h0000_1111);
    commit_and_check(3'b000, 32'h0, 32'h0000_3004);
    $display("txn stall: next=%h", imem_addr);

    // Reset while waiting for rvalid; stale rvalid after release is dropped
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h0000_3000);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stale_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("stale_inst", inst, 32'd0);
      chk("stale_req", {31'd0, imem_req}, 32'd1);
      chk("stale_addr", imem_addr, 32'h0000_3000);
    end
    imem_rvalid = 1'b0;
    $display("txn midreset: addr=%h inst_valid=%0d", imem_addr, inst_valid);

    // Misaligned jr target
    fetch_to_hold(32'h0000_3000, 32'h0000_0008);
`ifdef IFETCH_ALIGN_CHECK_EN
    commit = 1'b1; pc_src = 3'b001; rs_data = 32'h0000_3002;
    @(negedge clk);
    commit = 1'b0;
    chk("err_flag", {31'd0, fetch_err}, 32'd1);
    chk("err_pc", pc, 32'h0000_3000);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1; imem_rvalid = 1'b1; commit = 1'b1;
      @(negedge clk);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; commit = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", {31'd0, fetch_err}, 32'd0);
    chk("err_recover_req", {31'd0, imem_req}, 32'd1);
    $display("txn misaligned: fetch_err trapped, cleared by reset");
`else
    commit_and_check(3'b001, 32'h0000_3002, 32'h0000_3000);
    chk("noerr_flag", {31'd0, fetch_err}, 32'd0);
    $display("txn misaligned: forced aligned next=%h", imem_addr);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
